keycode_event_tracker: RTL and testbench

//  Consumes the 32-bit keycode word from the NIOS keycode PIO out_port: four 8-bit USB HID usage codes, 0x00 = empty slot.

---
 rtl/keycode_event_tracker.sv | 171 +++++++++++++++++
 tb/tb_keycode_event_tracker.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/keycode_event_tracker.sv
// Turns successive 4-slot HID keycode snapshots into press/release events queued in a FWFT FIFO.
// Optional KEYEV_HELD_MAP_EN adds a 256-bit held-key map output (key_held).
module keycode_event_tracker #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] keycode,
    output logic        ev_valid,
    output logic [8:0]  ev_data,
    input  logic        ev_ready,
    output logic        busy,
    output logic        overflow,
    input  logic        ovf_clr
`ifdef KEYEV_HELD_MAP_EN
    ,
    output logic [255:0] key_held
`endif
);

    // state      | meaning
    // IDLE       | waiting for kc_q to differ from cur_snap (and carry no ErrorRollOver)
    // SCAN_PRESS | walking new_snap slots, pushing codes absent from old_snap
    // SCAN_REL   | walking old_snap slots, pushing codes absent from new_snap
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SCAN_PRESS = 2'd1,
        SCAN_REL   = 2'd2
    } state_t;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    state_t      state, state_nxt;
    logic [31:0] kc_q;
    logic [31:0] cur_snap;
    logic [31:0] new_snap;
    logic [31:0] old_snap;
    logic [1:0]  idx;

    logic        has_err;
    logic        start;
    logic [31:0] self_snap;
    logic [31:0] other_snap;
    logic [7:0]  scan_code;
    logic        in_other;
    logic        in_prior;
    logic        push;
    logic [8:0]  push_data;

    function automatic logic [7:0] slot(input logic [31:0] w, input logic [1:0] i);
        return w[{i, 3'b000} +: 8];
    endfunction

    always_comb begin
        has_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (slot(kc_q, 2'(k)) == 8'h01) has_err = 1'b1;
        end
        start = (kc_q != cur_snap) && !has_err;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = SCAN_PRESS;
            SCAN_PRESS: if (idx == 2'd3) state_nxt = SCAN_REL;
            SCAN_REL:   if (idx == 2'd3) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // A slot emits only if its code is non-empty, missing from the opposite snapshot,
    // and not already seen in an earlier slot of the same snapshot.
    always_comb begin
        busy       = (state != IDLE);
        self_snap  = (state == SCAN_REL) ? old_snap : new_snap;
        other_snap = (state == SCAN_REL) ? new_snap : old_snap;
        scan_code  = slot(self_snap, idx);
        in_other   = 1'b0;
        in_prior   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (slot(other_snap, 2'(k)) == scan_code) in_other = 1'b1;
            if ((2'(k) < idx) && (slot(self_snap, 2'(k)) == scan_code)) in_prior = 1'b1;
        end
        push      = busy && (scan_code != 8'h00) && !in_other && !in_prior;
        push_data = {(state == SCAN_PRESS), scan_code};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kc_q     <= '0;
            cur_snap <= '0;
            new_snap <= '0;
            old_snap <= '0;
            idx      <= '0;
        end else begin
            kc_q <= keycode;
            case (state)
                IDLE: begin
                    if (start) begin
                        new_snap <= kc_q;
                        old_snap <= cur_snap;
                        idx      <= 2'd0;
                    end
                end
                SCAN_PRESS: idx <= idx + 2'd1;
                SCAN_REL: begin
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) cur_snap <= new_snap;
                end
                default: idx <= 2'd0;
            endcase
        end
    end

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en    = push && (!full || pop);
    assign ev_data  = ev_valid ? mem[rd_ptr] : 9'd0;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                      overflow <= 1'b0;
        else if (push && full && !pop)  overflow <= 1'b1;
        else if (ovf_clr)               overflow <= 1'b0;
    end

`ifdef KEYEV_HELD_MAP_EN
    // Tracks every generated event, including ones the FIFO had to drop.
    always_ff @(posedge clk) begin
        if (reset)     key_held <= '0;
        else if (push) key_held[push_data[7:0]] <= push_data[8];
    end
`endif

endmodule

// File: tb/tb_keycode_event_tracker.sv
// Scoreboard bench for keycode_event_tracker: expected events are queued when a snapshot
// is driven and compared as the DUT hands them out.
module tb_keycode_event_tracker;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] keycode;
    logic        ev_valid;
    logic [8:0]  ev_data;
    logic        ev_ready;
    logic        busy;
    logic        overflow;
    logic        ovf_clr;
`ifdef KEYEV_HELD_MAP_EN
    logic [255:0] key_held;
`endif

    keycode_event_tracker #(.FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .keycode  (keycode),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .busy     (busy),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef KEYEV_HELD_MAP_EN
        ,
        .key_held (key_held)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [8:0]  sb[$];
    logic [31:0] cur_m = '0;
    logic        exp_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has01(input logic [31:0] v);
        for (int k = 0; k < 4; k++) if (v[8*k +: 8] == 8'h01) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_snap(input logic [31:0] v, input logic [7:0] c, input int upto);
        for (int k = 0; k < upto; k++) if (v[8*k +: 8] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_exp(input logic [8:0] e);
        if (!ev_ready && sb.size() >= DEPTH) exp_ovf = 1'b1;
        else sb.push_back(e);
    endtask

    task automatic scan_into(input logic [31:0] o, input logic [31:0] n);
        logic [7:0] c;
        for (int k = 0; k < 4; k++) begin
            c = n[8*k +: 8];
            if (c != 8'h00 && !in_snap(o, c, 4) && !in_snap(n, c, k)) push_exp({1'b1, c});
        end
        for (int k = 0; k < 4; k++) begin
            c = o[8*k +: 8];
            if (c != 8'h00 && !in_snap(n, c, 4) && !in_snap(o, c, k)) push_exp({1'b0, c});
        end
    endtask

    task automatic apply(input logic [31:0] v);
        @(posedge clk); #1;
        keycode = v;
        if (v != cur_m && !has01(v)) begin
            scan_into(cur_m, v);
            cur_m = v;
        end
        repeat (14) @(posedge clk);
        #1;
        if (ev_ready) chk("drain", sb.size(), 0);
    endtask

    // Pop happens at the next rising edge; compare the head now.
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            if (sb.size() == 0) chk("unexp_ev", {23'd0, ev_data}, 32'h0);
            else chk("ev_data", {23'd0, ev_data}, {23'd0, sb.pop_front()});
        end
    end

    initial begin
        reset = 1'b1; keycode = '0; ev_ready = 1'b1; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", ev_valid, 0);
        chk("rst_data", ev_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);

        // single press with edge-accurate timing
        @(posedge clk); #1;
        keycode = 32'h0000_0004;
        sb.push_back(9'h104);
        cur_m = 32'h0000_0004;
        @(posedge clk);              // E0
        @(negedge clk); chk("busy_e0", busy, 0);
        @(posedge clk);              // E1
        @(negedge clk); chk("busy_e1", busy, 1); chk("valid_e1", ev_valid, 0);
        @(posedge clk);              // E2
        @(negedge clk); chk("valid_e2", ev_valid, 1);
        repeat (6) @(posedge clk);   // E8
        @(negedge clk); chk("busy_e8", busy, 1);
        @(posedge clk);              // E9
        @(negedge clk); chk("busy_e9", busy, 0);
        repeat (4) @(posedge clk);
        #1 chk("drain1", sb.size(), 0);

        apply(32'h0000_1604);
        apply(32'h0000_0016);
        apply(32'h0403_0201);        // ErrorRollOver: ignored
        chk("err_busy", busy, 0);
        apply(32'h0000_0016);        // equals cur_snap: nothing
        apply(32'h0000_0000);
        apply(32'h0707_0707);
        apply(32'h0000_0000);

        // overflow with a stalled consumer
        ev_ready = 1'b0;
        apply(32'h0000_0004);
        apply(32'h0000_0504);
        apply(32'h0006_0504);
        apply(32'h0706_0504);
        apply(32'h0706_0508);
        @(negedge clk);
        chk("ovf_set", overflow, exp_ovf);
        chk("ovf_valid", ev_valid, 1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        @(negedge clk); chk("ovf_clr", overflow, 0);
        @(posedge clk); #1 ev_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("drain_ovf", sb.size(), 0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] v;
            for (int k = 0; k < 4; k++) v[8*k +: 8] = 8'($urandom_range(0, 6));
            apply(v);
        end

        // reset in the middle of a press scan
        apply(32'h0000_0000);
        ev_ready = 1'b0;
        @(posedge clk); #1 keycode = 32'h0B0A_0908;
        repeat (4) @(posedge clk);   // E0..E3
        #1 reset = 1'b1;
        @(negedge clk); chk("pre_rst_head", ev_data, 9'h108);
        @(posedge clk);              // E4
        @(negedge clk); chk("rst_mid_valid", ev_valid, 0); chk("rst_mid_busy", busy, 0);
        @(posedge clk); #1 reset = 1'b0;
        sb.delete();
        ev_ready = 1'b1;
        scan_into(32'h0, 32'h0B0A_0908);
        cur_m = 32'h0B0A_0908;
        repeat (16) @(posedge clk);
        #1 chk("drain_rescan", sb.size(), 0);
        chk("final_ovf", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
